// File: rtl/dro_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dro_pkg
//  Purpose  : Shared types and default timing constants for the DRO cell
//             driver (command opcode, FSM state encoding, cycle defaults).
//  Revision : 1.0 - initial release
// ============================================================================
package dro_pkg;

    // Command opcode carried on cmd_op.
    typedef enum logic {
        DRO_WRITE = 1'b0,   // store a 1 (toggle the set line)
        DRO_READ  = 1'b1    // destructive read (toggle the reset line)
    } dro_op_e;

    // Driver FSM state encoding.
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RSP     = 3'd3,
        ST_GAP     = 3'd4
    } dro_state_e;

    // Default timing, in clk cycles.
    localparam int c_DEF_SEP_CYCLES    = 3;
    localparam int c_DEF_RD_WIN_CYCLES = 8;
    localparam int c_DEF_INIT_CYCLES   = 4;
    localparam int c_DEF_CNT_W         = 8;

endpackage : dro_pkg
`default_nettype wire

// File: rtl/dro_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : dro_driver_if
//  Purpose  : Command / response handshake bundle between a test sequencer
//             (master) and the DRO driver (slave).
//  Signals  : cmd_valid, cmd_ready, cmd_op   - command channel
//             rsp_valid, rsp_ready, rsp_data,
//             rsp_mismatch                   - read response channel
//  Revision : 1.0 - initial release
// ============================================================================
interface dro_driver_if;

    logic cmd_valid;
    logic cmd_ready;
    logic cmd_op;
    logic rsp_valid;
    logic rsp_ready;
    logic rsp_data;
    logic rsp_mismatch;

    // Sequencer side: issues commands, consumes responses.
    modport master (
        output cmd_valid,
        output cmd_op,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_mismatch
    );

    // Driver side: accepts commands, produces responses.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_mismatch
    );

endinterface : dro_driver_if
`default_nettype wire

// File: rtl/dro_toggle_sync.sv
`default_nettype none
// ============================================================================
//  Module   : dro_toggle_sync
//  Purpose  : Two-flop synchroniser for the asynchronous, toggle-coded cell
//             output, followed by a change detector. o_edge is high for one
//             cycle for every level change that reaches the synchronised
//             domain.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             i_async     - raw cell output
//             o_edge      - one-cycle toggle pulse (sync != sync_q)
//  Revision : 1.0 - initial release
// ============================================================================
module dro_toggle_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_async,
    output logic      o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
        end
    end

    assign o_edge = r_sync ^ r_sync_q;

endmodule : dro_toggle_sync
`default_nettype wire

// File: rtl/dro_driver.sv
`default_nettype none
// ============================================================================
//  Module   : dro_driver
//  Purpose  : Clocked initiator for one destructive-readout storage cell.
//             Write commands toggle dro_set, read commands toggle dro_reset
//             and watch the cell output for a toggle inside a fixed window;
//             the result is returned on the response channel. Enforces a
//             minimum gap between line edges and flags stray output toggles.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             bus (slave)       - cmd/rsp valid-ready channels
//             dro_set/dro_reset - toggle-coded lines into the cell
//             dro_out           - asynchronous toggle-coded cell output
//             err_spurious      - sticky unexpected-output flag
//             busy              - an operation is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dro_driver
    import dro_pkg::*;
#(
    parameter int SEP_CYCLES    = c_DEF_SEP_CYCLES,
    parameter int RD_WIN_CYCLES = c_DEF_RD_WIN_CYCLES,
    parameter int INIT_CYCLES   = c_DEF_INIT_CYCLES,
    parameter int CNT_W         = c_DEF_CNT_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dro_driver_if.slave bus,
    output logic        dro_set,
    output logic        dro_reset,
    input  wire logic   dro_out,
    output logic        err_spurious,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    generate
        if ((SEP_CYCLES < 1) || (RD_WIN_CYCLES < 3) || (INIT_CYCLES < 1) ||
            (SEP_CYCLES >= (1 << CNT_W)) || (RD_WIN_CYCLES >= (1 << CNT_W)) ||
            (INIT_CYCLES >= (1 << CNT_W))) begin : g_bad_params
            $error("dro_driver: illegal timing parameters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_SEP_LAST  = CNT_W'(SEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RD_LAST   = CNT_W'(RD_WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    dro_state_e       r_state;
    dro_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_edge;
    logic [1:0]       r_edge_cnt;    // saturating count of out edges in window
    logic [1:0]       w_edge_total;  // including the edge seen this cycle
    logic             w_accept;
    logic             w_rd_done;
    logic             w_rd_bit;

    logic             r_shadow;
    logic             r_set;
    logic             r_reset;
    logic             r_rsp_valid;
    logic             r_rsp_data;
    logic             r_rsp_mismatch;
    logic             r_err;

    // ------------------------------------------------------------------
    // Cell output synchroniser / toggle detector
    // ------------------------------------------------------------------
    dro_toggle_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (dro_out),
        .o_edge  (w_edge)
    );

    assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_rd_done = (r_state == ST_RD_WAIT) && (r_cnt == '0);
    assign w_rd_bit  = (w_edge_total != 2'd0);

    always_comb begin
        w_edge_total = r_edge_cnt;
        if (w_edge && (r_edge_cnt != 2'd3)) begin
            w_edge_total = r_edge_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and wait counter
    // INIT counts up from the reset value of 0; every other timed state
    // loads (cycles - 1) on entry and counts down, leaving at 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_INIT: begin
                if (r_cnt == c_INIT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    if (dro_op_e'(bus.cmd_op) == DRO_READ) begin
                        w_state_nxt = ST_RD_WAIT;
                        w_cnt_nxt   = c_RD_LAST;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = c_SEP_LAST;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RSP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_SEP_LAST;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // busy stays low in INIT so that every output reads 0 out of reset.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cmd_ready = 1'b0;
        busy          = 1'b0;
        unique case (r_state)
            ST_IDLE:                     bus.cmd_ready = 1'b1;
            ST_RD_WAIT, ST_RSP, ST_GAP:  busy          = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: line toggles, shadow bit, response and error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set          <= 1'b0;
            r_reset        <= 1'b0;
            r_shadow       <= 1'b0;
            r_edge_cnt     <= 2'd0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= 1'b0;
            r_rsp_mismatch <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            if (w_accept) begin
                if (dro_op_e'(bus.cmd_op) == DRO_READ) begin
                    r_reset <= ~r_reset;
                end else begin
                    r_set    <= ~r_set;
                    r_shadow <= 1'b1;
                end
            end

            // Window accumulator restarts with every read launch.
            if (w_accept) begin
                r_edge_cnt <= 2'd0;
            end else if (r_state == ST_RD_WAIT) begin
                r_edge_cnt <= w_edge_total;
            end

            if (w_rd_done) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= w_rd_bit;
                r_rsp_mismatch <= (w_rd_bit != r_shadow);
                r_shadow       <= 1'b0;
                if (w_edge_total >= 2'd2) begin
                    r_err <= 1'b1;
                end
            end else if ((r_state == ST_RSP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            // Output toggles outside a read window are unexpected; INIT is
            // excluded because the cell may still be settling from reset.
            if (w_edge && ((r_state == ST_IDLE) || (r_state == ST_GAP) ||
                           (r_state == ST_RSP))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dro_set          = r_set;
    assign dro_reset        = r_reset;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_mismatch = r_rsp_mismatch;
    assign err_spurious     = r_err;

endmodule : dro_driver
`default_nettype wire

// File: tb/tb_dro_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dro_driver
//  Purpose  : Self-checking bench for dro_driver with a behavioural DRO cell.
//             Read commands push their expected response into a scoreboard
//             queue; a monitor pops and compares on every response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dro_driver;
    import dro_pkg::*;

    typedef struct packed {
        logic data;
        logic mis;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dro_driver_if bus ();
    logic dro_set;
    logic dro_reset;
    logic dro_out;
    logic err_spurious;
    logic busy;

    dro_driver #(
        .SEP_CYCLES    (3),
        .RD_WIN_CYCLES (8),
        .INIT_CYCLES   (4),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .dro_set      (dro_set),
        .dro_reset    (dro_reset),
        .dro_out      (dro_out),
        .err_spurious (err_spurious),
        .busy         (busy)
    );

    // ------------------------------------------------------------------
    // Behavioural DRO cell: a set edge stores 1, a reset edge reads it out
    // (toggling out if a 1 was stored). Held cleared while rst_n is low.
    // force_tog lets the bench inject a stray output toggle.
    // ------------------------------------------------------------------
    logic cell_stored = 1'b0;
    logic cell_out    = 1'b0;
    logic force_tog   = 1'b0;
    assign dro_out = cell_out ^ force_tog;

    always @(dro_set) begin
        if (rst_n === 1'b1) cell_stored = 1'b1;
    end
    always @(dro_reset) begin
        if ((rst_n === 1'b1) && cell_stored) begin
            cell_out    = ~cell_out;
            cell_stored = 1'b0;
        end
    end
    always @(negedge rst_n) cell_stored = 1'b0;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_rsp = 0;
    int   rsp_rise_cyc = -1;
    int   set_q[$];
    int   rst_q[$];
    rsp_t exp_q[$];
    logic prev_set   = 1'b0;
    logic prev_rst   = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_last(input int q[$], input int back);
        if (q.size() <= back) return -1000;
        return q[q.size() - 1 - back];
    endfunction

    // Line-edge recorder and response monitor / scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (dro_set !== prev_set)   set_q.push_back(cyc);
        if (dro_reset !== prev_rst) rst_q.push_back(cyc);
        prev_set = dro_set;
        prev_rst = dro_reset;
        if (rst_n) begin
            if (bus.rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_mismatch", bus.rsp_mismatch, e.mis);
                end
            end
        end
        prev_valid = bus.rsp_valid;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (bus.cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Offer one command and return the cycle index of its accept edge.
    task automatic do_cmd(input logic op, output int acc);
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        acc           = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (n_rsp >= target) begin ok = 1; break; end
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int acc, a1, a2, m, low, n0;
        bit ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_mismatch", bus.rsp_mismatch, 0);
        chk("rst_dro_set", dro_set, 0);
        chk("rst_dro_reset", dro_reset, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: write then read
        do_cmd(1'b0, acc);
        @(negedge clk); #1;
        chk("t1_set_at_accept", q_last(set_q, 0), acc);
        chk("t1_busy", busy, 1);
        exp_q.push_back('{data: 1'b1, mis: 1'b0});
        bus.rsp_ready = 1'b1;
        n0 = n_rsp;
        do_cmd(1'b1, acc);
        wait_rsp(n0 + 1);
        chk("t1_reset_at_accept", q_last(rst_q, 0), acc);
        chk("t1_rsp_latency", rsp_rise_cyc - q_last(rst_q, 0), 8);

        // 2: read with nothing stored after reset
        apply_reset();
        exp_q.push_back('{data: 1'b0, mis: 1'b0});
        n0 = n_rsp;
        do_cmd(1'b1, acc);
        wait_rsp(n0 + 1);
        chk("t2_err", err_spurious, 0);

        // 3: back-to-back writes with cmd_valid held
        wait_idle();
        bus.cmd_op    = 1'b0;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        a1  = cyc;
        low = 0;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.cmd_ready) begin ok = 1; break; end
            low++;
        end
        @(posedge clk); #1;
        a2 = cyc;
        bus.cmd_valid = 1'b0;
        @(negedge clk); #1;
        chk("t3_ready_found", ok, 1);
        chk("t3_ready_low_cycles", low, 3);
        chk("t3_accept_spacing", a2 - a1, 4);
        chk("t3_set_spacing", q_last(set_q, 0) - q_last(set_q, 1), 4);

        // 4: read with response back-pressure
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{data: 1'b1, mis: 1'b0});
        n0 = n_rsp;
        do_cmd(1'b1, acc);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid) begin ok = 1; break; end
        end
        chk("t4_rsp_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_data", bus.rsp_data, 1);
            if (i < 4) begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        m = cyc;
        chk("t4_valid_dropped", bus.rsp_valid, 0);
        chk("t4_rsp_count", n_rsp, n0 + 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.cmd_ready) begin ok = 1; break; end
        end
        chk("t4_ready_after_hs", cyc - m, 3);

        // 5: stray output toggle while idle
        @(posedge clk); #1;
        force_tog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (err_spurious) break;
        end
        chk("t5_err_set", err_spurious, 1);
        exp_q.push_back('{data: 1'b1, mis: 1'b0});
        n0 = n_rsp;
        do_cmd(1'b0, acc);
        do_cmd(1'b1, acc);
        wait_rsp(n0 + 1);
        chk("t5_err_sticky", err_spurious, 1);

        // 6: reset during a read window
        do_cmd(1'b0, acc);
        do_cmd(1'b1, acc);
        n0 = n_rsp;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cmd_ready", bus.cmd_ready, 0);
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rsp_data", bus.rsp_data, 0);
        chk("t6_rsp_mismatch", bus.rsp_mismatch, 0);
        chk("t6_dro_set", dro_set, 0);
        chk("t6_dro_reset", dro_reset, 0);
        chk("t6_err", err_spurious, 0);
        chk("t6_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.cmd_ready) break;
            low++;
        end
        chk("t6_init_low_cycles", low, 4);
        repeat (12) @(negedge clk);
        #1;
        chk("t6_no_rsp", n_rsp, n0);
        exp_q.push_back('{data: 1'b0, mis: 1'b0});
        do_cmd(1'b1, acc);
        wait_rsp(n0 + 1);
        chk("t6_err_after", err_spurious, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_dro_driver
`default_nettype wire
